// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, the buffered result entry and
// an opcode legality helper used by every flag consumer.
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_SRA  = 4'h8;
  localparam logic [3:0] OP_SLT  = 4'h9;
  localparam logic [3:0] OP_SLTU = 4'hA;
  localparam logic [3:0] OP_LAND = 4'hB;
  localparam logic [3:0] OP_LOR  = 4'hC;
  localparam logic [3:0] OP_LAST = 4'hC;

  // Full-width ALU result entry as seen by 32-bit consumers.
  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic [3:0]            op;
    logic                  z;
    logic                  n;
    logic                  v;
  } alu_entry_t;

  // Codes above OP_LAST are not produced by any defined ALU operation.
  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > OP_LAST;
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational Z/N/V derivation from an ALU result, its opcode and the
// operand sign bits. Illegal opcodes yield all-zero flags.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op_i,
  input  logic              a_msb_i,
  input  logic              b_msb_i,
  input  logic [DATA_W-1:0] result_i,
  output logic              z_o,
  output logic              n_o,
  output logic              v_o,
  output logic              illegal_o
);

  logic r_msb;
  assign r_msb     = result_i[DATA_W-1];
  assign illegal_o = op_is_illegal(op_i);

  // Flags only carry meaning for defined opcodes; V only for add/subtract.
  always_comb begin
    z_o = 1'b0;
    n_o = 1'b0;
    v_o = 1'b0;
    if (!illegal_o) begin
      z_o = (result_i == '0);
      n_o = r_msb;
      case (op_i)
        OP_ADD:  v_o = (a_msb_i == b_msb_i) && (r_msb != a_msb_i);
        OP_SUB:  v_o = (a_msb_i != b_msb_i) && (r_msb != a_msb_i);
        default: v_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_queue.sv
// Buffers ALU results with their derived flags in a small FIFO and hands
// them to the consumer over valid/ready. Also tracks sticky overflow and
// illegal-opcode status.
module alu_result_queue
  import alu_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic              in_a_msb,
  input  logic              in_b_msb,
  input  logic [DATA_W-1:0] in_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_op,
  output logic              out_z,
  output logic              out_n,
  output logic              out_v,
  output logic [CNT_W-1:0]  count,
  output logic              sticky_v,
  output logic              sticky_ill,
  input  logic              flag_clr
);

  localparam int PTR_W = $clog2(DEPTH);

  // Width follows DATA_W so the queue can be reused for narrower datapaths.
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [3:0]        op;
    logic              z;
    logic              n;
    logic              v;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sticky_v_q, sticky_v_d;
  logic              sticky_ill_q, sticky_ill_d;

  logic   fg_z, fg_n, fg_v, fg_ill;
  logic   push, pop;
  entry_t in_entry;
  entry_t head;

  alu_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
    .op_i      (in_op),
    .a_msb_i   (in_a_msb),
    .b_msb_i   (in_b_msb),
    .result_i  (in_result),
    .z_o       (fg_z),
    .n_o       (fg_n),
    .v_o       (fg_v),
    .illegal_o (fg_ill)
  );

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign in_entry = '{result: in_result, op: in_op, z: fg_z, n: fg_n, v: fg_v};
  assign head     = mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy and sticky status; a set in the same
  // cycle as flag_clr takes priority over the clear.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    sticky_v_d   = flag_clr ? 1'b0 : sticky_v_q;
    sticky_ill_d = flag_clr ? 1'b0 : sticky_ill_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (push && fg_v)   sticky_v_d   = 1'b1;
    if (push && fg_ill) sticky_ill_d = 1'b1;
  end

  // Control state register; reset discards every buffered entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      sticky_v_q   <= 1'b0;
      sticky_ill_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      sticky_v_q   <= sticky_v_d;
      sticky_ill_q <= sticky_ill_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  // Head presentation, forced to zero while the queue is empty.
  always_comb begin
    out_result = '0;
    out_op     = '0;
    out_z      = 1'b0;
    out_n      = 1'b0;
    out_v      = 1'b0;
    if (out_valid) begin
      out_result = head.result;
      out_op     = head.op;
      out_z      = head.z;
      out_n      = head.n;
      out_v      = head.v;
    end
  end

  assign count      = count_q;
  assign sticky_v   = sticky_v_q;
  assign sticky_ill = sticky_ill_q;

endmodule

// File: tb/tb_alu_result_queue.sv
// Scenario bench for alu_result_queue with a scoreboard of expected entries.
module tb_alu_result_queue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic        in_a_msb, in_b_msb;
  logic [31:0] in_result;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_op;
  logic        out_z, out_n, out_v;
  logic [2:0]  count;
  logic        sticky_v, sticky_ill, flag_clr;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  op;
    logic        z;
    logic        n;
    logic        v;
  } ent_t;

  ent_t sb[$];
  ent_t e_exp;
  ent_t head;
  int   n_tests = 0;
  int   n_fail  = 0;

  assign head = {out_result, out_op, out_z, out_n, out_v};

  alu_result_queue #(.DATA_W(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a_msb   (in_a_msb),
    .in_b_msb   (in_b_msb),
    .in_result  (in_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_z      (out_z),
    .out_n      (out_n),
    .out_v      (out_v),
    .count      (count),
    .sticky_v   (sticky_v),
    .sticky_ill (sticky_ill),
    .flag_clr   (flag_clr)
  );

  always #5 clk = ~clk;

  // Reference flags for one ALU result.
  function automatic ent_t model(input logic [3:0] op, input logic a, input logic b,
                                 input logic [31:0] r);
    ent_t e;
    e.result = r;
    e.op     = op;
    e.z      = 1'b0;
    e.n      = 1'b0;
    e.v      = 1'b0;
    if (op <= 4'hC) begin
      e.z = (r == 32'd0);
      e.n = r[31];
      if (op == 4'h0)      e.v = (a == b) && (r[31] != a);
      else if (op == 4'h1) e.v = (a != b) && (r[31] != a);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic a, input logic b, input logic [31:0] r);
    in_valid  = 1'b1;
    in_op     = op;
    in_a_msb  = a;
    in_b_msb  = b;
    in_result = r;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
    in_op = 4'h0; in_a_msb = 1'b0; in_b_msb = 1'b0; in_result = 32'h0;
    repeat (2) tick();
    n_tests++;
    if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 3'd0}) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected %b", {out_valid, in_ready, count}, 5'b01000);
    end
    n_tests++;
    if ({sticky_v, sticky_ill} !== 2'b00) begin
      n_fail++; $display("FAIL reset_sticky: got %b expected 00", {sticky_v, sticky_ill});
    end
    n_tests++;
    if (head !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", head);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add_overflow();
    out_ready = 1'b0;
    drive(4'h0, 1'b0, 1'b0, 32'h8000_0000);
    sb.push_back(model(4'h0, 1'b0, 1'b0, 32'h8000_0000));
    tick();
    in_valid = 1'b0;
    n_tests++;
    if ({out_valid, count} !== {1'b1, 3'd1}) begin
      n_fail++; $display("FAIL add_latency: got %b expected 1001", {out_valid, count});
    end
    n_tests++;
    if ({out_z, out_n, out_v} !== 3'b011) begin
      n_fail++; $display("FAIL add_flags: got %b expected 011", {out_z, out_n, out_v});
    end
    n_tests++;
    if (sticky_v !== 1'b1) begin
      n_fail++; $display("FAIL add_sticky_v: got %b expected 1", sticky_v);
    end
    out_ready = 1'b1;
    e_exp = sb.pop_front();
    n_tests++;
    if (head !== e_exp) begin
      n_fail++; $display("FAIL add_head: got %h expected %h", head, e_exp);
    end
    tick();
    out_ready = 1'b0;
    n_tests++;
    if ({out_valid, count} !== {1'b0, 3'd0}) begin
      n_fail++; $display("FAIL add_empty: got %b expected 0000", {out_valid, count});
    end
  endtask

  task automatic test_sub_zero();
    out_ready = 1'b1;
    drive(4'h1, 1'b0, 1'b0, 32'h0);
    sb.push_back(model(4'h1, 1'b0, 1'b0, 32'h0));
    tick();
    in_valid = 1'b0;
    e_exp = sb.pop_front();
    n_tests++;
    if ({out_valid, out_z, out_n, out_v} !== 4'b1100) begin
      n_fail++; $display("FAIL sub_flags: got %b expected 1100", {out_valid, out_z, out_n, out_v});
    end
    n_tests++;
    if (head !== e_exp) begin
      n_fail++; $display("FAIL sub_head: got %h expected %h", head, e_exp);
    end
    tick();
    out_ready = 1'b0;
    n_tests++;
    if ({out_valid, count} !== {1'b0, 3'd0}) begin
      n_fail++; $display("FAIL sub_empty: got %b expected 0000", {out_valid, count});
    end
  endtask

  task automatic test_full();
    logic [31:0] r;
    logic [3:0]  op;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r  = (i == 2) ? 32'h0 : 32'h1111_1111 * (i + 1);
      op = 4'(4'h2 + i);
      drive(op, 1'b0, 1'b1, r);
      n_tests++;
      if (in_ready !== 1'(i < 4)) begin
        n_fail++; $display("FAIL full_in_ready[%0d]: got %b expected %b", i, in_ready, (i < 4));
      end
      if (i < 4) sb.push_back(model(op, 1'b0, 1'b1, r));
      tick();
    end
    in_valid = 1'b0;
    n_tests++;
    if ({count, in_ready, out_valid} !== {3'd4, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL full_state: got %b expected 10001", {count, in_ready, out_valid});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e_exp = sb.pop_front();
      n_tests++;
      if (head !== e_exp) begin
        n_fail++; $display("FAIL full_drain[%0d]: got %h expected %h", i, head, e_exp);
      end
      tick();
    end
    tick();
    out_ready = 1'b0;
    n_tests++;
    if ({out_valid, count, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL full_pop_empty: got %b expected 00001", {out_valid, count, in_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [3:0]  op;
    logic        a, b;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r = $urandom; op = 4'($urandom_range(0, 12));
      a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1));
      drive(op, a, b, r);
      sb.push_back(model(op, a, b, r));
      tick();
    end
    in_valid = 1'b0;
    n_tests++;
    if (count !== 3'd2) begin
      n_fail++; $display("FAIL b2b_fill: got %0d expected 2", count);
    end
    for (int i = 0; i < 10; i++) begin
      r = $urandom; op = 4'($urandom_range(0, 12));
      a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1));
      drive(op, a, b, r);
      out_ready = 1'b1;
      e_exp = sb.pop_front();
      n_tests++;
      if (head !== e_exp) begin
        n_fail++; $display("FAIL b2b_head[%0d]: got %h expected %h", i, head, e_exp);
      end
      sb.push_back(model(op, a, b, r));
      tick();
      n_tests++;
      if (count !== 3'd2) begin
        n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, count);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_exp = sb.pop_front();
      n_tests++;
      if (head !== e_exp) begin
        n_fail++; $display("FAIL b2b_drain[%0d]: got %h expected %h", i, head, e_exp);
      end
      tick();
    end
    out_ready = 1'b0;
    n_tests++;
    if (count !== 3'd0) begin
      n_fail++; $display("FAIL b2b_empty: got %0d expected 0", count);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    flag_clr  = 1'b1;
    tick();
    flag_clr  = 1'b0;
    n_tests++;
    if ({sticky_v, sticky_ill} !== 2'b00) begin
      n_fail++; $display("FAIL ill_clear: got %b expected 00", {sticky_v, sticky_ill});
    end
    drive(4'hE, 1'b1, 1'b1, 32'h8000_0000);
    sb.push_back(model(4'hE, 1'b1, 1'b1, 32'h8000_0000));
    tick();
    in_valid = 1'b0;
    n_tests++;
    if ({sticky_v, sticky_ill} !== 2'b01) begin
      n_fail++; $display("FAIL ill_sticky: got %b expected 01", {sticky_v, sticky_ill});
    end
    n_tests++;
    if ({out_valid, out_z, out_n, out_v, out_op} !== {4'b1000, 4'hE}) begin
      n_fail++; $display("FAIL ill_entry: got %b expected 10001110", {out_valid, out_z, out_n, out_v, out_op});
    end
    drive(4'h0, 1'b1, 1'b1, 32'h0000_0001);
    flag_clr = 1'b1;
    sb.push_back(model(4'h0, 1'b1, 1'b1, 32'h0000_0001));
    tick();
    flag_clr = 1'b0;
    in_valid = 1'b0;
    n_tests++;
    if ({sticky_v, sticky_ill} !== 2'b10) begin
      n_fail++; $display("FAIL ill_set_wins: got %b expected 10", {sticky_v, sticky_ill});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e_exp = sb.pop_front();
      n_tests++;
      if (head !== e_exp) begin
        n_fail++; $display("FAIL ill_drain[%0d]: got %h expected %h", i, head, e_exp);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(4'h0, 1'b0, 1'b0, 32'h8000_0000 | 32'(i));
      sb.push_back(model(4'h0, 1'b0, 1'b0, 32'h8000_0000 | 32'(i)));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    e_exp = sb.pop_front();
    n_tests++;
    if (head !== e_exp) begin
      n_fail++; $display("FAIL arst_head: got %h expected %h", head, e_exp);
    end
    tick();
    out_ready = 1'b0;
    n_tests++;
    if ({count, sticky_v} !== {3'd3, 1'b1}) begin
      n_fail++; $display("FAIL arst_pre: got %b expected 0111", {count, sticky_v});
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({out_valid, count, sticky_v, sticky_ill} !== 6'b000000) begin
      n_fail++; $display("FAIL arst_drop: got %b expected 000000", {out_valid, count, sticky_v, sticky_ill});
    end
    n_tests++;
    if (head !== '0) begin
      n_fail++; $display("FAIL arst_data: got %h expected 0", head);
    end
    #2 rst = 1'b0;
    sb.delete();
    drive(4'h4, 1'b0, 1'b0, 32'hCAFE_F00D);
    sb.push_back(model(4'h4, 1'b0, 1'b0, 32'hCAFE_F00D));
    tick();
    in_valid = 1'b0;
    e_exp = sb.pop_front();
    n_tests++;
    if ({count, head} !== {3'd1, e_exp}) begin
      n_fail++; $display("FAIL arst_new: got %0d/%h expected 1/%h", count, head, e_exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if ({out_valid, count} !== 4'b0000) begin
      n_fail++; $display("FAIL arst_final: got %b expected 0000", {out_valid, count});
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_full();
    test_back_to_back();
    test_illegal();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
